// File: rtl/pipelined_addsub_if.sv
// -----------------------------------------------------------------------------
// pipelined_addsub_if
//   Operand/result bundle for pipelined_addsub.
//
//   master : drives the operands, watches the results (the datapath user)
//   slave  : the adder/subtractor itself
//
//   en        pipeline advance; 0 = every register holds
//   in_valid  a/b/cin/sub carry a valid operation this cycle
//   sub       0 = add, 1 = subtract
//   a, b      WIDTH-bit operands (unsigned or two's complement)
//   cin       carry-in for add, borrow-in for subtract
//   out_valid sum/cout/ovf hold a completed result
//   sum       WIDTH-bit result
//   cout      raw carry out of the MSB (for subtract, 1 = no borrow)
//   ovf       signed overflow
// -----------------------------------------------------------------------------
interface pipelined_addsub_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic             in_valid;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output en, in_valid, sub, a, b, cin,
    input  out_valid, sum, cout, ovf
  );

  modport slave (
    input  en, in_valid, sub, a, b, cin,
    output out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_addsub.sv
// -----------------------------------------------------------------------------
// pipelined_addsub
//   Skewed-pipeline WIDTH-bit adder/subtractor. The operands are split into
//   STAGES chunks of C = WIDTH/STAGES bits; stage k resolves chunk k and hands
//   its carry to stage k+1 through a register. WIDTH must be divisible by
//   STAGES, and the interface WIDTH must match the module WIDTH.
//
//   Latency: an operation captured at edge N is presented at edge
//   N+STAGES-1 (enabled edges only). One operation per enabled cycle.
//
//   Ports
//     clk   rising-edge clock
//     rst   asynchronous, active-high reset; clears every pipeline register
//     bus   pipelined_addsub_if.slave (en, in_valid, sub, a, b, cin in;
//           out_valid, sum, cout, ovf out)
//
//   Operand word layout: each stage works on the low C bits of its A word,
//   then rotates right by C with the fresh sum chunk inserted at the top.
//   After STAGES rotations the A word is exactly the finished sum, so the
//   completed lower chunks and the unconsumed upper operand chunks share one
//   register. B only shrinks, since its consumed chunks are never needed.
// -----------------------------------------------------------------------------
module pipelined_addsub #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  pipelined_addsub_if.slave    bus
);

  localparam int C = WIDTH / STAGES;

  // Output register (the final stage writes straight into it).
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             ovf_q;
  logic             out_valid_q;

  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // Width of the B bits still to be consumed on entry to this stage.
    localparam int BW = WIDTH - k * C;

    logic [WIDTH-1:0] a_in;
    logic [BW-1:0]    b_in;
    logic             c_in;
    logic             v_in;
    logic [C:0]       chunk;   // {carry out, C-bit chunk sum}
    logic [WIDTH-1:0] a_d;

    if (k == 0) begin : g_first
      // Subtract as a + ~b + 1; cin then becomes a borrow-in.
      assign a_in = bus.a;
      assign b_in = bus.b ^ {WIDTH{bus.sub}};
      assign c_in = bus.cin ^ bus.sub;
      assign v_in = bus.in_valid;
    end else begin : g_next
      assign a_in = g_stage[k-1].g_reg.a_q;
      assign b_in = g_stage[k-1].g_reg.b_q;
      assign c_in = g_stage[k-1].g_reg.c_q;
      assign v_in = g_stage[k-1].g_reg.v_q;
    end

    assign chunk = {1'b0, a_in[C-1:0]} + {1'b0, b_in[C-1:0]} + {{C{1'b0}}, c_in};

    if (C == WIDTH) begin : g_whole
      assign a_d = chunk[C-1:0];
    end else begin : g_rot
      assign a_d = {chunk[C-1:0], a_in[WIDTH-1:C]};
    end

    if (k < STAGES - 1) begin : g_reg
      logic [WIDTH-1:0] a_q;
      logic [BW-C-1:0]  b_q;
      logic             c_q;
      logic             v_q;

      // NOTE: non-blocking assignments make every stage sample its
      // predecessor's pre-edge value, so the chain shifts by exactly one
      // stage per enabled edge regardless of block evaluation order.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
          c_q <= 1'b0;
          v_q <= 1'b0;
        end else if (bus.en) begin
          a_q <= a_d;
          b_q <= b_in[BW-1:C];
          c_q <= chunk[C];
          v_q <= v_in;
        end
      end
    end else begin : g_last
      // Carry into the MSB is recovered from the MSB sum bit: s ^ a ^ b.
      logic msb_cin;
      assign msb_cin = a_in[C-1] ^ b_in[C-1] ^ chunk[C-1];

      // NOTE: result fields load only when a valid operation arrives, so a
      // bubble or idle period leaves the last result on the outputs while
      // out_valid alone tracks the valid chain.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          sum_q       <= '0;
          cout_q      <= 1'b0;
          ovf_q       <= 1'b0;
          out_valid_q <= 1'b0;
        end else if (bus.en) begin
          out_valid_q <= v_in;
          if (v_in) begin
            sum_q  <= a_d;
            cout_q <= chunk[C];
            ovf_q  <= msb_cin ^ chunk[C];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_pipelined_addsub.sv
// -----------------------------------------------------------------------------
// tb_pipelined_addsub
//   Drives three instances (STAGES = 4, 1, 16; WIDTH = 16) with one common
//   stimulus stream. Every accepted operation pushes its expected result and
//   capture edge onto a per-instance queue; a monitor per instance pops and
//   compares whenever a result emerges on an enabled edge, including the
//   exact latency, and checks that outputs stay frozen across stalls.
// -----------------------------------------------------------------------------
module tb_pipelined_addsub;

  localparam int W = 16;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic [31:0]  cap;   // enabled-edge index at which the op is captured
  } exp_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         in_valid = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  int checks = 0;
  int failures = 0;

  logic [31:0] edge_cnt = '0;
  logic        en_edge = 1'b0;

  exp_t sb [3][$];

  logic         ov_w  [3];
  logic [W-1:0] sum_w [3];
  logic         co_w  [3];
  logic         of_w  [3];

  always #5 clk = ~clk;

  always @(posedge clk) begin
    en_edge <= en && !rst;
    if (en && !rst) edge_cnt <= edge_cnt + 32'd1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int ST = (g == 0) ? 4 : ((g == 1) ? 1 : 16);

    pipelined_addsub_if #(.WIDTH(W)) bus ();

    assign bus.en       = en;
    assign bus.in_valid = in_valid;
    assign bus.sub      = sub;
    assign bus.a        = a;
    assign bus.b        = b;
    assign bus.cin      = cin;

    pipelined_addsub #(.WIDTH(W), .STAGES(ST)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
    );

    assign ov_w[g]  = bus.out_valid;
    assign sum_w[g] = bus.sum;
    assign co_w[g]  = bus.cout;
    assign of_w[g]  = bus.ovf;

    logic         p_live = 1'b0;
    logic         p_ov, p_co, p_of;
    logic [W-1:0] p_sum;

    always @(negedge clk) begin : mon
      exp_t e;
      if (rst) begin
        p_live = 1'b0;
      end else begin
        if (!en_edge && p_live) begin
          check($sformatf("S%0d stall out_valid", ST), 32'(bus.out_valid), 32'(p_ov));
          check($sformatf("S%0d stall sum", ST), 32'(bus.sum), 32'(p_sum));
          check($sformatf("S%0d stall cout", ST), 32'(bus.cout), 32'(p_co));
          check($sformatf("S%0d stall ovf", ST), 32'(bus.ovf), 32'(p_of));
        end else if (en_edge && bus.out_valid) begin
          if (sb[g].size() == 0) begin
            check($sformatf("S%0d unexpected out_valid", ST), 32'(bus.out_valid), 32'd0);
          end else begin
            e = sb[g].pop_front();
            check($sformatf("S%0d sum", ST), 32'(bus.sum), 32'(e.sum));
            check($sformatf("S%0d cout", ST), 32'(bus.cout), 32'(e.cout));
            check($sformatf("S%0d ovf", ST), 32'(bus.ovf), 32'(e.ovf));
            check($sformatf("S%0d latency", ST), edge_cnt - e.cap, 32'(ST - 1));
          end
        end
        p_live = 1'b1;
        p_ov   = bus.out_valid;
        p_sum  = bus.sum;
        p_co   = bus.cout;
        p_of   = bus.ovf;
      end
    end
  end

  // Reference: plain 17-bit arithmetic, overflow from operand/result signs.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mc, input logic ms);
    logic [W:0]   full;
    logic [W-1:0] bb;
    exp_t         r;
    bb     = ms ? ~mb : mb;
    full   = {1'b0, ma} + {1'b0, bb} + {{W{1'b0}}, mc ^ ms};
    r.sum  = full[W-1:0];
    r.cout = full[W];
    r.ovf  = (ma[W-1] == bb[W-1]) && (full[W-1] != ma[W-1]);
    r.cap  = '0;
    return r;
  endfunction

  task automatic drive(input logic ie, input logic iv, input logic [W-1:0] ia,
                       input logic [W-1:0] ib, input logic ic, input logic is);
    @(negedge clk);
    en = ie; in_valid = iv; a = ia; b = ib; cin = ic; sub = is;
  endtask

  task automatic push(input exp_t e);
    exp_t x;
    x = e;
    x.cap = edge_cnt + 32'd1;
    for (int i = 0; i < 3; i++) sb[i].push_back(x);
  endtask

  task automatic op(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic, input logic is);
    drive(1'b1, 1'b1, ia, ib, ic, is);
    push(model(ia, ib, ic, is));
  endtask

  task automatic op_exp(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic,
                        input logic is, input logic [W-1:0] es, input logic ec, input logic eo);
    exp_t e;
    drive(1'b1, 1'b1, ia, ib, ic, is);
    e.sum = es; e.cout = ec; e.ovf = eo; e.cap = '0;
    push(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  // en=0 with in_valid=1 and junk operands: must be ignored entirely.
  task automatic stall(input int n);
    for (int i = 0; i < n; i++)
      drive(1'b0, 1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
  endtask

  task automatic drain();
    for (int t = 0; t < 40 && (sb[0].size() + sb[1].size() + sb[2].size()) != 0; t++) idle(1);
    for (int i = 0; i < 3; i++) check($sformatf("drain dut%0d pending", i), 32'(sb[i].size()), 32'd0);
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin : stim
    // 1. Reset, then idle: outputs stay cleared.
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) check($sformatf("reset out_valid dut%0d", i), 32'(ov_w[i]), 32'd0);
    rst = 1'b0;
    en = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        check($sformatf("idle out_valid dut%0d", i), 32'(ov_w[i]), 32'd0);
        check($sformatf("idle sum dut%0d", i), 32'(sum_w[i]), 32'd0);
        check($sformatf("idle cout dut%0d", i), 32'(co_w[i]), 32'd0);
        check($sformatf("idle ovf dut%0d", i), 32'(of_w[i]), 32'd0);
      end
    end

    // 2. Carry across chunks and signed overflow.
    op_exp(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    op_exp(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    op_exp(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    // 3. Subtraction and borrow-in.
    op_exp(16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    op_exp(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    op_exp(16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0);
    drain();

    // 4. Streaming with a bubble and a 3-cycle stall mid-stream.
    op(16'h1234, 16'h4321, 1'b0, 1'b0);
    op(16'hA5A5, 16'h5A5A, 1'b1, 1'b0);
    op(16'h8000, 16'h8000, 1'b0, 1'b0);
    idle(1);
    op(16'h0F0F, 16'hF0F1, 1'b0, 1'b1);
    stall(3);
    op(16'h7FFF, 16'hFFFF, 1'b0, 1'b1);
    op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    drain();

    // 5. Reset with operations in flight: nothing may emerge.
    op(16'h1111, 16'h2222, 1'b0, 1'b0);
    op(16'h3333, 16'h4444, 1'b1, 1'b0);
    op(16'h5555, 16'h0001, 1'b0, 1'b1);
    @(posedge clk);
    #2;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("midreset out_valid dut%0d", i), 32'(ov_w[i]), 32'd0);
      check($sformatf("midreset sum dut%0d", i), 32'(sum_w[i]), 32'd0);
      sb[i].delete();
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    idle(20);

    // 6. Random traffic with random bubbles and stalls.
    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 9) == 0) stall(1);
      if ($urandom_range(0, 4) == 0) idle(1);
      op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined N-bit adder/subtractor; the successor to the single-bit ripple full adder.
- Splits operands into STAGES equal chunks and resolves one chunk per clock, with the carry registered between stages.
- Carries a valid bit alongside the data and supports a global stall.
- Sits in the datapath library as the building block for wide accumulators and ALUs.

Parameters:
- WIDTH, 16, operand/result width in bits; must be divisible by STAGES.
- STAGES, 4, number of pipeline stages (1..WIDTH); chunk width C = WIDTH/STAGES.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  pipeline advance; 0 = every register holds
- in_valid  input  1  operands on a/b/cin/sub are valid this cycle
- sub  input  1  0 = add, 1 = subtract
- a  input  WIDTH  operand A (unsigned / two's complement)
- b  input  WIDTH  operand B
- cin  input  1  carry-in (add) / borrow-in (sub)
- out_valid  output  1  sum/cout/ovf hold a completed result
- sum  output  WIDTH  result
- cout  output  1  carry out of MSB (raw carry; for sub, 1 = no borrow)
- ovf  output  1  signed overflow

Behaviour:
- Reset (async, immediate): every pipeline register clears to 0.
  - out_valid=0, sum=0, cout=0, ovf=0.
- Operand conditioning at capture: b_eff = b XOR {WIDTH{sub}}; c0 = cin XOR sub.
  - add: a+b+cin.
  - sub, cin=0: a-b.
  - sub, cin=1: a-b-1.
- Stage k (k = 0..STAGES-1) computes chunk k: bits [k*C +: C] of a + b_eff + carry_k.
  - carry_0 = c0; carry_k comes from stage k-1's register.
  - Completed lower chunks and the unconsumed upper operand chunks travel forward in stage registers (skewed pipeline).
- Latency: result for an operand captured at edge N appears at edge N+STAGES-1.
  - Observed STAGES cycles after in_valid is sampled, counting enabled edges only.
  - Throughput: one operation per enabled cycle.
- en=0: no register changes, including the valid chain and outputs. Nothing is lost or duplicated. in_valid is ignored while en=0.
- Valid chain: one bit per stage, shifts on every en=1 edge. in_valid=0 inserts a bubble.
- Output register loads sum/cout/ovf only on an en=1 edge where the final stage's valid is 1. Otherwise it holds the last result.
  - out_valid follows the final valid bit.
- cout = carry out of bit WIDTH-1.
- ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
- Reset mid-operation: in-flight operations are discarded, with no partial output. The first operation after reset deasserts obeys normal latency.
- STAGES=1 degenerates to a registered WIDTH-bit add/sub with one-cycle latency; same flags.
- STAGES=WIDTH gives C=1; each stage is one full-adder cell.
- No combinational path from any input to any output.

Test Plan (WIDTH=16, STAGES=4 unless stated):
1. Assert rst for 2 cycles, then hold in_valid=0 with en=1 for 10 cycles -> out_valid=0, sum=0x0000, cout=0, ovf=0 throughout.
2. Carry propagation across chunks and signed overflow:
   - a=0x00FF, b=0x0001, cin=0, sub=0 -> 4 cycles later sum=0x0100, cout=0, ovf=0.
   - a=0xFFFF, b=0x0001 -> sum=0x0000, cout=1, ovf=0.
   - a=0x7FFF, b=0x0001 -> sum=0x8000, cout=0, ovf=1.
3. Subtraction and borrow-in:
   - a=0x0005, b=0x0007, sub=1, cin=0 -> sum=0xFFFE, cout=0, ovf=0.
   - a=0x8000, b=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
   - a=0x0010, b=0x0003, sub=1, cin=1 -> sum=0x000C, cout=1.
4. Streaming with bubbles and stalls:
   - Issue 6 back-to-back ops with a bubble after op 3; drop en=0 for 3 cycles mid-stream.
   - Required: results emerge in order, each exactly once, bubble visible as one out_valid=0 cycle, outputs frozen during the stall.
5. Reset mid-operation: issue 3 ops, assert rst one cycle later -> out_valid=0 immediately; none of the 3 results ever appear.
6. Randomised checks against a reference model:
   - Repeat scenarios 2–4 with STAGES=1 (latency 1) and STAGES=16 (latency 16).
   - 1000 random {a, b, cin, sub} vectors per configuration -> every result matches the model.
